// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: accepts one decoded instruction, fetches both operands,
// hands them to the ALU over a valid/response handshake and optionally writes the result back.
module rf_access_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              instr_wb,
  output logic [ADDR_W-1:0] rf_addr_op1,
  output logic [ADDR_W-1:0] rf_addr_op2,
  input  logic [DATA_W-1:0] rf_out_op1,
  input  logic [DATA_W-1:0] rf_out_op2,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_load,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_res_valid,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy,
  output logic [15:0]       retire_count
);

  typedef enum logic [2:0] {StIdle, StRdIssue, StRdCapt, StExec, StWb} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] rf_addr_op1_q, rf_addr_op1_d;
  logic [ADDR_W-1:0] rf_addr_op2_q, rf_addr_op2_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              rf_load_q, rf_load_d;
  logic              alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [15:0]       retire_q, retire_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    wb_d          = wb_q;
    rf_addr_op1_d = rf_addr_op1_q;
    rf_addr_op2_d = rf_addr_op2_q;
    rf_addr_d     = rf_addr_q;
    rf_data_d     = rf_data_q;
    rf_load_d     = rf_load_q;
    alu_valid_d   = alu_valid_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    retire_d      = retire_q;
    instr_ready   = (state_q == StIdle) && rst_n;

    unique case (state_q)
      StIdle: begin
        if (instr_valid && instr_ready) begin
          op_d          = instr_op;
          rd_d          = instr_rd;
          wb_d          = instr_wb;
          // Read addresses are registered here so they are already presented during RD_ISSUE.
          rf_addr_op1_d = instr_rs1;
          rf_addr_op2_d = instr_rs2;
          state_d       = StRdIssue;
        end
      end
      StRdIssue: state_d = StRdCapt;
      StRdCapt: begin
        alu_a_d     = rf_out_op1;
        alu_b_d     = rf_out_op2;
        alu_op_d    = op_q;
        alu_valid_d = 1'b1;
        state_d     = StExec;
      end
      StExec: begin
        if (alu_res_valid) begin
          rf_data_d   = alu_res;
          rf_addr_d   = rd_q;
          alu_valid_d = 1'b0;
          if (wb_q) begin
            rf_load_d = 1'b1;
            state_d   = StWb;
          end else begin
            retire_d = retire_q + 16'd1;
            state_d  = StIdle;
          end
        end
      end
      StWb: begin
        rf_load_d = 1'b0;
        retire_d  = retire_q + 16'd1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      rf_addr_op1_q <= '0;
      rf_addr_op2_q <= '0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
      rf_load_q     <= 1'b0;
      alu_valid_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      retire_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      wb_q          <= wb_d;
      rf_addr_op1_q <= rf_addr_op1_d;
      rf_addr_op2_q <= rf_addr_op2_d;
      rf_addr_q     <= rf_addr_d;
      rf_data_q     <= rf_data_d;
      rf_load_q     <= rf_load_d;
      alu_valid_q   <= alu_valid_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      retire_q      <= retire_d;
    end
  end

  assign rf_addr_op1  = rf_addr_op1_q;
  assign rf_addr_op2  = rf_addr_op2_q;
  assign rf_addr      = rf_addr_q;
  assign rf_data      = rf_data_q;
  assign rf_load      = rf_load_q;
  assign alu_valid    = alu_valid_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign busy         = (state_q != StIdle);
  assign retire_count = retire_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer: table of instructions against a register-file model,
// plus hand-written reset-in-flight and stray-response sequences.
module tb_rf_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rs1, instr_rs2, instr_rd;
  logic        instr_wb;
  logic [2:0]  rf_addr_op1, rf_addr_op2, rf_addr;
  logic [15:0] rf_out_op1 = '0;
  logic [15:0] rf_out_op2 = '0;
  logic [15:0] rf_data;
  logic        rf_load;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_res_valid;
  logic [15:0] alu_res;
  logic        busy;
  logic [15:0] retire_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_retire = '0;

  // Register-file model: write when rf_load, otherwise registered read.
  logic [15:0] mem [8] = '{16'd10, 16'd0, 16'd100, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};

  always @(posedge clk) begin
    if (rf_load) begin
      mem[rf_addr] <= rf_data;
    end else begin
      rf_out_op1 <= mem[rf_addr_op1];
      rf_out_op2 <= mem[rf_addr_op2];
    end
  end

  always #5 clk = ~clk;

  rf_access_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_rd      (instr_rd),
    .instr_wb      (instr_wb),
    .rf_addr_op1   (rf_addr_op1),
    .rf_addr_op2   (rf_addr_op2),
    .rf_out_op1    (rf_out_op1),
    .rf_out_op2    (rf_out_op2),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data),
    .rf_load       (rf_load),
    .alu_valid     (alu_valid),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_res_valid (alu_res_valid),
    .alu_res       (alu_res),
    .busy          (busy),
    .retire_count  (retire_count)
  );

  typedef struct {
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [3:0]  op;
    logic        wb;
    int          stall;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bench ALU: op 0 adds, op 1 subtracts.
  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    return (op == 4'd0) ? a + b : a - b;
  endfunction

  task automatic run_vec(input vec_t v);
    int budget = 0;
    while (!instr_ready && budget < 20) begin
      step();
      budget++;
    end
    chk("ready_before_accept", instr_ready, 1);
    instr_valid = 1'b1;
    instr_rs1   = v.rs1;
    instr_rs2   = v.rs2;
    instr_rd    = v.rd;
    instr_op    = v.op;
    instr_wb    = v.wb;
    step();  // cycle 1: RD_ISSUE
    instr_valid = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_ready", instr_ready, 0);
    chk("c1_addr_op1", rf_addr_op1, v.rs1);
    chk("c1_addr_op2", rf_addr_op2, v.rs2);
    chk("c1_rf_load", rf_load, 0);
    step();  // cycle 2: RD_CAPT
    chk("c2_alu_valid", alu_valid, 0);
    step();  // cycle 3: EXEC
    chk("c3_alu_valid", alu_valid, 1);
    chk("c3_alu_a", alu_a, v.exp_a);
    chk("c3_alu_b", alu_b, v.exp_b);
    chk("c3_alu_op", alu_op, v.op);
    for (int s = 0; s < v.stall; s++) begin
      alu_res_valid = 1'b0;
      step();
      chk("stall_alu_valid", alu_valid, 1);
      chk("stall_alu_a", alu_a, v.exp_a);
      chk("stall_alu_b", alu_b, v.exp_b);
      chk("stall_alu_op", alu_op, v.op);
      chk("stall_rf_load", rf_load, 0);
    end
    alu_res_valid = 1'b1;
    alu_res       = alu_model(alu_op, alu_a, alu_b);
    step();
    alu_res_valid = 1'b0;
    chk("resp_alu_valid", alu_valid, 0);
    chk("resp_rf_addr", rf_addr, v.rd);
    chk("resp_rf_data", rf_data, v.exp_res);
    if (v.wb) begin
      chk("wb_rf_load", rf_load, 1);
      chk("wb_ready", instr_ready, 0);
      step();
      chk("post_wb_rf_load", rf_load, 0);
    end else begin
      chk("nowb_rf_load", rf_load, 0);
    end
    exp_retire++;
    chk("retire_ready", instr_ready, 1);
    chk("retire_count", retire_count, exp_retire);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rs1: 3'd0, rs2: 3'd2, rd: 3'd5, op: 4'd0, wb: 1'b1, stall: 0,
                exp_a: 16'd10, exp_b: 16'd100, exp_res: 16'd110};
    vecs[1] = '{rs1: 3'd0, rs2: 3'd2, rd: 3'd5, op: 4'd0, wb: 1'b0, stall: 0,
                exp_a: 16'd10, exp_b: 16'd100, exp_res: 16'd110};
    vecs[2] = '{rs1: 3'd5, rs2: 3'd3, rd: 3'd6, op: 4'd0, wb: 1'b1, stall: 0,
                exp_a: 16'd110, exp_b: 16'd1, exp_res: 16'd111};
    vecs[3] = '{rs1: 3'd2, rs2: 3'd0, rd: 3'd7, op: 4'd1, wb: 1'b1, stall: 3,
                exp_a: 16'd100, exp_b: 16'd10, exp_res: 16'd90};
    vecs[4] = '{rs1: 3'd7, rs2: 3'd7, rd: 3'd7, op: 4'd0, wb: 1'b1, stall: 1,
                exp_a: 16'd90, exp_b: 16'd90, exp_res: 16'd180};
    vecs[5] = '{rs1: 3'd6, rs2: 3'd7, rd: 3'd1, op: 4'd1, wb: 1'b0, stall: 2,
                exp_a: 16'd111, exp_b: 16'd180, exp_res: 16'hFFBB};

    rst_n         = 1'b0;
    instr_valid   = 1'b1;
    instr_op      = '0;
    instr_rs1     = '0;
    instr_rs2     = '0;
    instr_rd      = '0;
    instr_wb      = 1'b0;
    alu_res_valid = 1'b0;
    alu_res       = '0;
    step();
    step();
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rf_load", rf_load, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_rf_data", rf_data, 0);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    #1;
    chk("release_ready", instr_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    chk("mem1_untouched", mem[1], 0);
    chk("mem7_written", mem[7], 180);

    // Reset while the instruction sits in EXEC.
    instr_valid = 1'b1;
    instr_rs1   = 3'd0;
    instr_rs2   = 3'd2;
    instr_rd    = 3'd3;
    instr_op    = 4'd0;
    instr_wb    = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    chk("mid_exec_alu_valid", alu_valid, 1);
    rst_n         = 1'b0;
    instr_valid   = 1'b1;
    alu_res_valid = 1'b1;
    alu_res       = 16'hBEEF;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_valid", alu_valid, 0);
    chk("midrst_rf_load", rf_load, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_addr_op1", rf_addr_op1, 0);
    chk("midrst_retire", retire_count, 0);
    chk("midrst_ready", instr_ready, 0);
    step();
    chk("midrst_no_accept", busy, 0);
    chk("midrst_rf_load2", rf_load, 0);
    exp_retire    = '0;
    rst_n         = 1'b1;
    instr_valid   = 1'b0;
    alu_res_valid = 1'b0;
    #1;
    chk("midrst_release_ready", instr_ready, 1);
    step();
    chk("mem3_not_written", mem[3], 1);

    // Continuous offer with a permanently asserted ALU response: one accept per 4-cycle visit.
    instr_valid   = 1'b1;
    instr_rs1     = 3'd0;
    instr_rs2     = 3'd2;
    instr_rd      = 3'd4;
    instr_op      = 4'd0;
    instr_wb      = 1'b0;
    alu_res_valid = 1'b1;
    alu_res       = 16'h1234;
    for (int c = 0; c < 12; c++) begin
      chk("stray_ready", instr_ready, ((c % 4) == 0) ? 1 : 0);
      chk("stray_alu_valid", alu_valid, ((c % 4) == 3) ? 1 : 0);
      chk("stray_rf_load", rf_load, 0);
      step();
    end
    instr_valid   = 1'b0;
    alu_res_valid = 1'b0;
    exp_retire    = exp_retire + 16'd3;
    chk("stray_retire", retire_count, exp_retire);
    chk("stray_rf_data", rf_data, 16'h1234);
    chk("stray_rf_addr", rf_addr, 4);
    step();
    chk("stray_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_access_sequencer.md
Name: rf_access_sequencer

Overview:
- Initiator side of the CPU register-file port; drives read addresses, write address, write data and the load strobe of the 8x16 register file.
- Takes one decoded instruction at a time (rs1, rs2, rd, op, writeback flag) and fetches both operands.
- Hands the operands to the ALU with a valid/response handshake, then writes the result back.
- Sits between the decoder and the register file/ALU; one instruction in flight.

Parameters:
DATA_W, 16, register and ALU data width
ADDR_W, 3, register address width (8 registers)
OP_W, 4, ALU opcode width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  decoder offers an instruction
instr_ready  out  1  sequencer accepts an instruction; high only in IDLE
instr_op  in  OP_W  ALU opcode
instr_rs1  in  ADDR_W  source register 1
instr_rs2  in  ADDR_W  source register 2
instr_rd  in  ADDR_W  destination register
instr_wb  in  1  1 = write result back to rd
rf_addr_op1  out  ADDR_W  register-file read address, operand 1
rf_addr_op2  out  ADDR_W  register-file read address, operand 2
rf_out_op1  in  DATA_W  register-file read data 1; registered, valid one clock after address
rf_out_op2  in  DATA_W  register-file read data 2
rf_addr  out  ADDR_W  register-file write address
rf_data  out  DATA_W  register-file write data
rf_load  out  1  register-file write strobe; 1 = write, 0 = read
alu_valid  out  1  operands valid to ALU
alu_op  out  OP_W  opcode to ALU
alu_a  out  DATA_W  operand 1
alu_b  out  DATA_W  operand 2
alu_res_valid  in  1  ALU result valid
alu_res  in  DATA_W  ALU result
busy  out  1  instruction in flight (state != IDLE)
retire_count  out  16  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset: state IDLE; all registered outputs 0 (rf_load=0, alu_valid=0, alu_a/b=0, rf_addr/rf_data/rf_addr_op1/op2=0, alu_op=0, retire_count=0).
  - instr_ready = (state==IDLE) & rst_n, so it is 0 while rst_n low and 1 in the first cycle after release.
- Register-file contract: the file writes when rf_load=1 and reads only when rf_load=0, on the same posedge. rf_load is therefore 1 only in WB, for exactly one cycle.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, EXEC, WB.
- IDLE: on instr_valid & instr_ready, latch op/rs1/rs2/rd/wb, then go to RD_ISSUE. No accept in any other state.
- RD_ISSUE: rf_addr_op1=rs1, rf_addr_op2=rs2, rf_load=0, then go to RD_CAPT.
- RD_CAPT: file data is now valid; register rf_out_op1/op2 into alu_a/alu_b and alu_op=op, then go to EXEC.
- EXEC: alu_valid=1; alu_a/b/op held stable.
  - When alu_res_valid=1 is sampled: latch alu_res into rf_data, rd into rf_addr, and drop alu_valid.
  - If wb=1, go to WB.
  - If wb=0, go to IDLE and retire.
  - Any number of wait cycles is allowed.
- WB: rf_load=1 with rf_addr/rf_data stable, then go to IDLE and retire. rf_load returns to 0 next cycle.
- alu_res_valid outside EXEC: ignored.
- Latency, with accept at cycle 0 and a zero-wait ALU:
  - RD_ISSUE at cycle 1, RD_CAPT at cycle 2, alu_valid at cycle 3, rf_load at cycle 4.
  - instr_ready again at cycle 5 for wb=1, or cycle 4 for wb=0.
- Read-after-write: a write lands at the WB edge, and the next RD_ISSUE comes at least one cycle later, so new data is always read. No forwarding is needed. rd==rs1==rs2 is legal.
- retire_count: +1 per retire; wraps 0xFFFF to 0x0000.
- Read addresses and write address/data hold their last value outside their states; they are harmless because rf_load=0.
- Reset mid-operation: abandon the instruction, return to IDLE next edge, no rf_load pulse, retire_count cleared.

Test Plan:
- File model mem0=10, mem2=100; accept rs1=0, rs2=2, rd=5, op=ADD, wb=1; ALU responds same cycle -> cycle 3: alu_a=10, alu_b=100; cycle 4: rf_load=1, rf_addr=5, rf_data=110; retire_count=1; instr_ready=1 at cycle 5.
- Same instruction with wb=0 -> rf_load never high; retire_count=1; instr_ready=1 at cycle 4.
- ALU stalls alu_res_valid for 3 cycles -> alu_valid high 4 cycles, alu_a/b/op constant, rf_load only on the cycle after the response.
- Back-to-back: write r5=110, then rs1=5, rs2=3 (mem3=1) -> second alu_a=110, alu_b=1.
- rst_n low during EXEC -> next cycle all outputs 0, no rf_load, retire_count=0; instr_valid held high during reset is not accepted.
- instr_valid held high continuously with alu_res_valid pulsing in IDLE/RD_* -> exactly one accept per IDLE visit; stray responses do not advance the FSM.
